// File: rtl/pixel_remap_engine_pkg.sv
// Shared FSM state type and sizing helpers for the pixel remap engine.
// No ports: imported by pixel_remap_engine and raster_counter.
package pixel_remap_engine_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN,
    DONE
  } state_t;

  function automatic int calcLat(
    input int rdLat,
    input int warpLat
  );
    return (rdLat > warpLat) ? rdLat : warpLat;
  endfunction

  function automatic int dropWidth(
    input int w,
    input int h
  );
    return $clog2(w * h + 1);
  endfunction

  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pixel_remap_engine_raster.sv
// raster_counter: row/column scan of a W x H frame plus linear index.
// Ports: clk, rst, clr, en in; i, j, lin, last (at H-1, W-1) out.
module raster_counter
  import pixel_remap_engine_pkg::*;
#(
  parameter int W = 640,
  parameter int H = 480,
  localparam int IW = idxWidth(H),
  localparam int JW = idxWidth(W),
  localparam int LW = idxWidth(W * H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [IW-1:0] i,
  output logic [JW-1:0] j,
  output logic [LW-1:0] lin,
  output logic          last
);

  logic iEnd;
  logic jEnd;

  assign iEnd = (i == IW'(H - 1));
  assign jEnd = (j == JW'(W - 1));
  assign last = iEnd & jEnd;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      i   <= '0;
      j   <= '0;
      lin <= '0;
    end else if (en) begin
      lin <= lin + LW'(1);
      if (jEnd) begin
        j <= '0;
        i <= iEnd ? '0 : i + IW'(1);
      end else begin
        j <= j + JW'(1);
      end
    end
  end

endmodule

// File: rtl/pixel_remap_engine.sv
// pixel_remap_engine: raster-scans a source frame, remaps each pixel
// through an external warp unit (or identity) and writes it to dst.
// Ports: start/warp_en/src_base/dst_base control in; busy/done/
// drop_count status out; rd_* RAM read port; warp_* warp unit link;
// wr_* RAM write port.
module pixel_remap_engine
  import pixel_remap_engine_pkg::*;
#(
  parameter int W        = 640,
  parameter int H        = 480,
  parameter int DW       = 8,
  parameter int AW       = 21,
  parameter int RD_LAT   = 1,
  parameter int WARP_LAT = 1,
  localparam int DCW = dropWidth(W, H)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           warp_en,
  input  logic [AW-1:0]  src_base,
  input  logic [AW-1:0]  dst_base,
  output logic           busy,
  output logic           done,
  output logic [DCW-1:0] drop_count,
  output logic           rd_en,
  output logic [AW-1:0]  rd_addr,
  input  logic [DW-1:0]  rd_data,
  output logic [9:0]     warp_i,
  output logic [9:0]     warp_j,
  input  logic [AW-1:0]  warp_off,
  input  logic           warp_oob,
  output logic           wr_en,
  output logic [AW-1:0]  wr_addr,
  output logic [DW-1:0]  wr_data
);

  localparam int LAT  = calcLat(RD_LAT, WARP_LAT);
  localparam int DLAT = LAT - RD_LAT;
  localparam int WLAT = LAT - WARP_LAT;
  localparam int IW   = idxWidth(H);
  localparam int JW   = idxWidth(W);
  localparam int LW   = idxWidth(W * H);
  localparam int CW   = idxWidth(LAT);

  state_t        state;
  logic          warpEn;
  logic [AW-1:0] srcBase;
  logic [AW-1:0] dstBase;
  logic [CW-1:0] drainCnt;

  logic [IW-1:0] i;
  logic [JW-1:0] j;
  logic [LW-1:0] lin;
  logic          last;
  logic          scan;
  logic          accept;

  assign scan   = (state == SCAN);
  assign accept = (state == IDLE) & start;
  assign busy   = scan | (state == DRAIN);
  assign done   = (state == DONE);

  raster_counter #(
    .W(W),
    .H(H)
  ) uRaster (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .en  (scan),
    .i   (i),
    .j   (j),
    .lin (lin),
    .last(last)
  );

  assign rd_en   = scan;
  assign rd_addr = scan ? srcBase + AW'(lin) : '0;
  assign warp_i  = scan ? 10'(i) : '0;
  assign warp_j  = scan ? 10'(j) : '0;

  // Issue tag: valid bit (flushed on reset) and linear index, LAT deep.
  logic [LAT-1:0] vPipe;
  logic [LW-1:0]  linPipe [LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      vPipe <= '0;
    end else begin
      vPipe[0] <= scan;
      for (int k = 1; k < LAT; k++) begin
        vPipe[k] <= vPipe[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    linPipe[0] <= lin;
    for (int k = 1; k < LAT; k++) begin
      linPipe[k] <= linPipe[k-1];
    end
  end

  // Pad the faster of RAM data / warp result up to the common slot.
  logic [DW-1:0] pix;

  if (DLAT == 0) begin : gPixThru
    assign pix = rd_data;
  end else begin : gPixDly
    logic [DW-1:0] pipe [DLAT];
    always_ff @(posedge clk) begin
      pipe[0] <= rd_data;
      for (int k = 1; k < DLAT; k++) begin
        pipe[k] <= pipe[k-1];
      end
    end
    assign pix = pipe[DLAT-1];
  end

  logic [AW:0] warpIn;
  logic [AW:0] warpD;

  assign warpIn = {warp_oob, warp_off};

  if (WLAT == 0) begin : gWarpThru
    assign warpD = warpIn;
  end else begin : gWarpDly
    logic [AW:0] pipe [WLAT];
    always_ff @(posedge clk) begin
      pipe[0] <= warpIn;
      for (int k = 1; k < WLAT; k++) begin
        pipe[k] <= pipe[k-1];
      end
    end
    assign warpD = pipe[WLAT-1];
  end

  logic          slotV;
  logic [LW-1:0] slotLin;
  logic          oobD;
  logic [AW-1:0] offD;
  logic          dropHit;
  logic [AW-1:0] offSel;

  assign slotV   = vPipe[LAT-1];
  assign slotLin = linPipe[LAT-1];
  assign oobD    = warpD[AW];
  assign offD    = warpD[AW-1:0];
  assign dropHit = slotV & warpEn & oobD;
  assign offSel  = warpEn ? offD : AW'(slotLin);

  assign wr_en   = slotV & ~(warpEn & oobD);
  assign wr_addr = wr_en ? dstBase + offSel : '0;
  assign wr_data = wr_en ? pix : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      warpEn     <= 1'b0;
      srcBase    <= '0;
      dstBase    <= '0;
      drainCnt   <= '0;
      drop_count <= '0;
    end else begin
      if (dropHit) begin
        drop_count <= drop_count + DCW'(1);
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            warpEn     <= warp_en;
            srcBase    <= src_base;
            dstBase    <= dst_base;
            drop_count <= '0;
            state      <= SCAN;
          end
        end
        SCAN: begin
          if (last) begin
            drainCnt <= '0;
            state    <= DRAIN;
          end
        end
        DRAIN: begin
          if (drainCnt == CW'(LAT - 1)) begin
            state <= DONE;
          end else begin
            drainCnt <= drainCnt + CW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_remap_engine.sv
// Bench: two engines (latency 1/1 and 2/3) on a 4x3 frame, checked
// against a frame-level write-stream model of the remap rules.
module tb_pixel_remap_engine;

  localparam int TW = 4;
  localparam int TH = 3;
  localparam int N  = TW * TH;

  logic       clk = 1'b0;
  logic       rst;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  logic        start   [2];
  logic        warpEnI [2];
  logic [20:0] srcB    [2];
  logic [20:0] dstB    [2];
  logic        busy    [2];
  logic        done    [2];
  logic [3:0]  dropCnt [2];
  logic        rdEn    [2];
  logic [20:0] rdAddr  [2];
  logic [7:0]  rdData  [2];
  logic [9:0]  warpI   [2];
  logic [9:0]  warpJ   [2];
  logic [20:0] warpOff [2];
  logic        oob     [2];
  logic        wrEn    [2];
  logic [20:0] wrAddr  [2];
  logic [7:0]  wrData  [2];

  int offMode [2];
  int oobMode [2];
  int seed    [2];
  int latOf   [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pixel_remap_engine #(
    .W(TW), .H(TH), .DW(8), .AW(21),
    .RD_LAT(1), .WARP_LAT(1)
  ) dut0 (
    .clk(clk), .rst(rst), .start(start[0]),
    .warp_en(warpEnI[0]), .src_base(srcB[0]),
    .dst_base(dstB[0]), .busy(busy[0]), .done(done[0]),
    .drop_count(dropCnt[0]), .rd_en(rdEn[0]),
    .rd_addr(rdAddr[0]), .rd_data(rdData[0]),
    .warp_i(warpI[0]), .warp_j(warpJ[0]),
    .warp_off(warpOff[0]), .warp_oob(oob[0]),
    .wr_en(wrEn[0]), .wr_addr(wrAddr[0]),
    .wr_data(wrData[0])
  );

  pixel_remap_engine #(
    .W(TW), .H(TH), .DW(8), .AW(21),
    .RD_LAT(2), .WARP_LAT(3)
  ) dut1 (
    .clk(clk), .rst(rst), .start(start[1]),
    .warp_en(warpEnI[1]), .src_base(srcB[1]),
    .dst_base(dstB[1]), .busy(busy[1]), .done(done[1]),
    .drop_count(dropCnt[1]), .rd_en(rdEn[1]),
    .rd_addr(rdAddr[1]), .rd_data(rdData[1]),
    .warp_i(warpI[1]), .warp_j(warpJ[1]),
    .warp_off(warpOff[1]), .warp_oob(oob[1]),
    .wr_en(wrEn[1]), .wr_addr(wrAddr[1]),
    .wr_data(wrData[1])
  );

  function automatic logic [7:0] pixFn(
    input logic [20:0] a, input int s);
    return 8'((int'(a) * 7) + s);
  endfunction

  function automatic logic [20:0] offFn(
    input int m, input int i, input int j, input int s);
    case (m)
      0:       return 21'(i * TW + j);
      1:       return 21'(i * TW + TW - 1 - j);
      default: return 21'((i * 37 + j * 11 + s) % 512);
    endcase
  endfunction

  function automatic bit oobFn(
    input int m, input int i, input int j, input int s);
    case (m)
      0:       return 1'b0;
      1:       return (j == 0);
      default: return ((i * 5 + j * 3 + s) % 4) == 0;
    endcase
  endfunction

  // RAM read port and warp unit models with their own latencies.
  logic [7:0]  rp [2][4];
  logic [21:0] wp [2][4];

  always @(posedge clk) begin
    for (int n = 0; n < 2; n++) begin
      rp[n][0] <= rdEn[n] ? pixFn(rdAddr[n], seed[n]) : 8'hA5;
      wp[n][0] <= {oobFn(oobMode[n], int'(warpI[n]),
                         int'(warpJ[n]), seed[n]),
                   offFn(offMode[n], int'(warpI[n]),
                         int'(warpJ[n]), seed[n])};
      for (int k = 1; k < 4; k++) begin
        rp[n][k] <= rp[n][k-1];
        wp[n][k] <= wp[n][k-1];
      end
    end
  end

  assign rdData[0]  = rp[0][0];
  assign rdData[1]  = rp[1][1];
  assign warpOff[0] = wp[0][0][20:0];
  assign oob[0]     = wp[0][0][21];
  assign warpOff[1] = wp[1][2][20:0];
  assign oob[1]     = wp[1][2][21];

  typedef struct {
    int n;
    int a;
    int d;
    int c;
  } wr_t;

  wr_t wq[$];
  wr_t expQ[$];
  int  firstRd  [2];
  int  doneCnt  [2];
  int  doneCyc  [2];
  int  doneBusy [2];

  always @(negedge clk) begin
    for (int n = 0; n < 2; n++) begin
      if (rdEn[n] && firstRd[n] < 0) firstRd[n] = cyc;
      if (wrEn[n])
        wq.push_back('{n, int'(wrAddr[n]),
                       int'(wrData[n]), cyc});
      if (done[n]) begin
        doneCnt[n]++;
        doneCyc[n] = cyc;
        if (busy[n]) doneBusy[n] = 1;
      end
    end
  end

  task automatic chk(input string name,
                     input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d",
               name, act, req);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chkIdle(input int n, input string tag);
    chk($sformatf("%s_busy%0d", tag, n), busy[n], 0);
    chk($sformatf("%s_done%0d", tag, n), done[n], 0);
    chk($sformatf("%s_rden%0d", tag, n), rdEn[n], 0);
    chk($sformatf("%s_wren%0d", tag, n), wrEn[n], 0);
    chk($sformatf("%s_rdaddr%0d", tag, n), rdAddr[n], 0);
    chk($sformatf("%s_wraddr%0d", tag, n), wrAddr[n], 0);
    chk($sformatf("%s_wrdata%0d", tag, n), wrData[n], 0);
    chk($sformatf("%s_wi%0d", tag, n), warpI[n], 0);
    chk($sformatf("%s_wj%0d", tag, n), warpJ[n], 0);
    chk($sformatf("%s_drops%0d", tag, n), dropCnt[n], 0);
  endtask

  task automatic startFrame(input int n, input bit we,
    input logic [20:0] s, input logic [20:0] d,
    output int sc);
    step();
    wq.delete();
    firstRd[n]  = -1;
    doneCnt[n]  = 0;
    doneBusy[n] = 0;
    warpEnI[n]  = we;
    srcB[n]     = s;
    dstB[n]     = d;
    start[n]    = 1'b1;
    @(posedge clk);
    #1;
    start[n] = 1'b0;
    sc = cyc;
  endtask

  task automatic runFrame(input int n, input bit we,
    input int om, input int bm,
    input logic [20:0] s, input logic [20:0] d,
    input int sd, input bit pulse,
    output int dutDrops, output int dutWr);
    int sc;
    int drops;
    int lat;
    int m;
    offMode[n] = om;
    oobMode[n] = bm;
    seed[n]    = sd;
    lat        = latOf[n];
    startFrame(n, we, s, d, sc);
    for (int t = 0; t < 200 && doneCnt[n] == 0; t++) begin
      step();
      if (pulse && cyc == sc + 5) begin
        start[n]   = 1'b1;
        dstB[n]    = 21'h777;
        warpEnI[n] = ~we;
      end
      if (pulse && cyc == sc + 6) start[n] = 1'b0;
    end
    chk("done_seen", doneCnt[n], 1);
    chk("first_rd", firstRd[n] - sc, 0);
    chk("done_cyc", doneCyc[n] - sc, N + lat);
    chk("busy_in_done", doneBusy[n], 0);
    if (pulse) begin
      start[n] = 1'b1;
      step();
      start[n] = 1'b0;
      chk("start_in_done_rden", rdEn[n], 0);
      chk("start_in_done_busy", busy[n], 0);
    end
    expQ.delete();
    drops = 0;
    for (int k = 0; k < N; k++) begin
      int i;
      int j;
      logic [20:0] a;
      logic [20:0] wa;
      i = k / TW;
      j = k % TW;
      a = s + 21'(k);
      if (we && oobFn(bm, i, j, sd)) begin
        drops++;
      end else begin
        wa = we ? d + offFn(om, i, j, sd) : d + 21'(k);
        expQ.push_back('{n, int'(wa),
                         int'(pixFn(a, sd)), sc + k + lat});
      end
    end
    chk("drop_count", dropCnt[n], drops);
    chk("write_count", wq.size(), expQ.size());
    m = (wq.size() < expQ.size()) ? wq.size() : expQ.size();
    for (int k = 0; k < m; k++) begin
      chk($sformatf("wr%0d_inst", k), wq[k].n, expQ[k].n);
      chk($sformatf("wr%0d_addr", k), wq[k].a, expQ[k].a);
      chk($sformatf("wr%0d_data", k), wq[k].d, expQ[k].d);
      chk($sformatf("wr%0d_cyc", k), wq[k].c - sc,
          expQ[k].c - sc);
    end
    dutDrops = int'(dropCnt[n]);
    dutWr    = wq.size();
  endtask

  typedef struct {
    int          n;
    bit          we;
    int          om;
    int          bm;
    logic [20:0] s;
    logic [20:0] d;
    int          expDrops;
    int          expWr;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int dd;
    int dw;
    int sc;
    tbl[0] = '{0, 1'b0, 0, 1, 21'd0, 21'd100, 0, 12};
    tbl[1] = '{0, 1'b1, 1, 0, 21'd16, 21'd200, 0, 12};
    tbl[2] = '{0, 1'b1, 0, 1, 21'd0, 21'd40, 3, 9};
    tbl[3] = '{1, 1'b1, 0, 0, 21'd0, 21'd60, 0, 12};
    tbl[4] = '{1, 1'b0, 2, 2, 21'h1FFFF8, 21'h1FFFFA, 0, 12};
    tbl[5] = '{1, 1'b1, 2, 1, 21'd8, 21'd300, 3, 9};
    latOf[0] = 1;
    latOf[1] = 3;
    for (int n = 0; n < 2; n++) begin
      start[n]   = 1'b0;
      warpEnI[n] = 1'b0;
      srcB[n]    = '0;
      dstB[n]    = '0;
      offMode[n] = 0;
      oobMode[n] = 0;
      seed[n]    = 0;
      firstRd[n] = -1;
      doneCnt[n] = 0;
      doneCyc[n] = 0;
      doneBusy[n] = 0;
    end
    rst = 1'b1;
    repeat (3) step();
    chkIdle(0, "reset");
    chkIdle(1, "reset");
    rst = 1'b0;

    for (int v = 0; v < 6; v++) begin
      runFrame(tbl[v].n, tbl[v].we, tbl[v].om, tbl[v].bm,
               tbl[v].s, tbl[v].d, 17 + v, 1'b0, dd, dw);
      chk($sformatf("tbl%0d_drops", v), dd, tbl[v].expDrops);
      chk($sformatf("tbl%0d_writes", v), dw, tbl[v].expWr);
    end

    // start mid-frame and in the done cycle must be ignored
    runFrame(0, 1'b1, 1, 0, 21'd4, 21'd500, 9, 1'b1, dd, dw);
    chk("pulse_writes", dw, 12);
    runFrame(0, 1'b0, 0, 0, 21'd2, 21'd80, 5, 1'b0, dd, dw);
    chk("after_pulse_writes", dw, 12);

    // reset while pixel 5 is being issued
    offMode[0] = 0;
    oobMode[0] = 0;
    seed[0]    = 3;
    startFrame(0, 1'b1, 21'd0, 21'd150, sc);
    for (int t = 0; t < 50 && cyc < sc + 5; t++) step();
    rst = 1'b1;
    step();
    chkIdle(0, "midrst");
    rst = 1'b0;
    wq.delete();
    doneCnt[0] = 0;
    repeat (20) step();
    chk("midrst_no_writes", wq.size(), 0);
    chk("midrst_no_done", doneCnt[0], 0);
    runFrame(0, 1'b1, 0, 1, 21'd7, 21'd90, 11, 1'b0, dd, dw);
    chk("after_rst_writes", dw, 9);

    for (int r = 0; r < 8; r++) begin
      runFrame($urandom_range(0, 1), 1'($urandom_range(0, 1)),
               $urandom_range(0, 2), $urandom_range(0, 2),
               21'($urandom), 21'($urandom),
               $urandom_range(0, 255), 1'b0, dd, dw);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
